// File: rtl/multicycle_ctrl_fsm_if.sv
// Control/handshake bundle between the multi-cycle sequencer and the datapath/memory port.
interface multicycle_ctrl_fsm_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       alu_src;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       mem_to_reg;
  logic       instr_done;
  logic       illegal_op;
  logic       bus_err;
  logic [2:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output mem_read, mem_write, ir_write, pc_write, pc_src, alu_src, alu_op,
           reg_write, mem_to_reg, instr_done, illegal_op, bus_err, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  mem_read, mem_write, ir_write, pc_write, pc_src, alu_src, alu_op,
           reg_write, mem_to_reg, instr_done, illegal_op, bus_err, state
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback with
// per-state datapath controls decoded combinationally from the current state and latched opcode.
module multicycle_ctrl_fsm #(
  parameter logic [6:0]  OP_RTYPE  = 7'h33,
  parameter logic [6:0]  OP_LOAD   = 7'h03,
  parameter logic [6:0]  OP_STORE  = 7'h23,
  parameter logic [6:0]  OP_BRANCH = 7'h63,
  parameter int unsigned MEM_TMO   = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_ctrl_fsm_if.master  dp_io
);

  localparam int unsigned TMO_W = 8;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_ADDR   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_BRANCH = 3'd5;
  localparam logic [2:0] S_WB     = 3'd6;
  localparam logic [2:0] S_IDLE   = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [6:0]       op_q, op_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;
  logic             is_load;

  logic       mem_read, mem_write, ir_write, pc_write, pc_src, alu_src;
  logic [1:0] alu_op;
  logic       reg_write, mem_to_reg, instr_done, illegal_op, bus_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tmo_q   <= tmo_d;
    end
  end

  // Timeout counter stays at zero outside a stalled FETCH/MEM, so every entry starts from zero.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    tmo_d      = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;
    illegal_op = 1'b0;
    bus_err    = 1'b0;
    is_load    = (op_q == OP_LOAD);
    tmo_hit    = (tmo_q == TMO_W'(MEM_TMO)) && !dp_io.mem_ready;

    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (dp_io.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo_hit) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DECODE: begin
        op_d = dp_io.opcode;
        case (dp_io.opcode)
          OP_RTYPE:          state_d = S_EXEC;
          OP_LOAD, OP_STORE: state_d = S_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        alu_op  = 2'b10;
        state_d = S_WB;
      end
      S_ADDR: begin
        alu_src = 1'b1;
        state_d = S_MEM;
      end
      // Only loads and stores reach MEM, so anything not a load is a store.
      S_MEM: begin
        alu_src   = 1'b1;
        mem_read  = is_load;
        mem_write = !is_load;
        if (dp_io.mem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (tmo_hit) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_BRANCH: begin
        alu_op     = 2'b01;
        pc_write   = dp_io.zero;
        pc_src     = dp_io.zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = is_load;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign dp_io.mem_read   = mem_read;
  assign dp_io.mem_write  = mem_write;
  assign dp_io.ir_write   = ir_write;
  assign dp_io.pc_write   = pc_write;
  assign dp_io.pc_src     = pc_src;
  assign dp_io.alu_src    = alu_src;
  assign dp_io.alu_op     = alu_op;
  assign dp_io.reg_write  = reg_write;
  assign dp_io.mem_to_reg = mem_to_reg;
  assign dp_io.instr_done = instr_done;
  assign dp_io.illegal_op = illegal_op;
  assign dp_io.bus_err    = bus_err;
  assign dp_io.state      = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-instruction cycle scripts build an expected trace,
// which is replayed against the DUT one cycle at a time.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] OP_RTYPE  = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam int         MEM_TMO   = 15;

  localparam logic [2:0] F = 3'd0, D = 3'd1, EX = 3'd2, AD = 3'd3,
                         ME = 3'd4, BR = 3'd5, WB = 3'd6, ID = 3'd7;

  localparam logic [12:0] C_MR   = 13'h1000;
  localparam logic [12:0] C_MW   = 13'h0800;
  localparam logic [12:0] C_IRW  = 13'h0400;
  localparam logic [12:0] C_PCW  = 13'h0200;
  localparam logic [12:0] C_PCS  = 13'h0100;
  localparam logic [12:0] C_ALUS = 13'h0080;
  localparam logic [12:0] C_AOP1 = 13'h0040;
  localparam logic [12:0] C_AOP0 = 13'h0020;
  localparam logic [12:0] C_RW   = 13'h0010;
  localparam logic [12:0] C_M2R  = 13'h0008;
  localparam logic [12:0] C_DONE = 13'h0004;
  localparam logic [12:0] C_ILL  = 13'h0002;
  localparam logic [12:0] C_BERR = 13'h0001;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [6:0]  opc;
    logic        z;
    logic [2:0]  st;
    logic [12:0] ctl;
  } cyc_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   done_cnt;
  int   berr_cnt;
  cyc_t q[$];

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dp_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] junk_op();
    return 7'($urandom);
  endfunction

  function automatic logic junk_bit();
    return 1'($urandom);
  endfunction

  task automatic push(input logic r, input logic rdy, input logic [6:0] opc, input logic z,
                      input logic [2:0] st, input logic [12:0] ctl);
    cyc_t c;
    c.rst = r; c.rdy = rdy; c.opc = opc; c.z = z; c.st = st; c.ctl = ctl;
    q.push_back(c);
  endtask

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  // Stall cycles of a memory request; ok=0 when the request times out.
  task automatic mem_wait(input logic [2:0] st, input logic [12:0] req, input int waits,
                          output bit ok);
    ok = 1'b1;
    for (int i = 0; i < waits; i++) begin
      if (i == MEM_TMO) begin
        push(1'b1, 1'b0, junk_op(), junk_bit(), st, req | C_BERR);
        ok = 1'b0;
        return;
      end
      push(1'b1, 1'b0, junk_op(), junk_bit(), st, req);
    end
  endtask

  // Expected trace of one instruction, starting in FETCH.
  task automatic instr(input logic [6:0] opc, input logic z, input int fw, input int mw);
    bit ok;
    bit legal;
    bit ld;
    mem_wait(F, C_MR, fw, ok);
    if (!ok) return;
    push(1'b1, 1'b1, junk_op(), junk_bit(), F, C_MR | C_IRW | C_PCW);
    legal = (opc == OP_RTYPE) || (opc == OP_LOAD) || (opc == OP_STORE) || (opc == OP_BRANCH);
    push(1'b1, junk_bit(), opc, junk_bit(), D, legal ? 13'h0 : C_ILL);
    if (!legal) return;
    if (opc == OP_RTYPE) begin
      push(1'b1, 1'b1, junk_op(), junk_bit(), EX, C_AOP1);
      push(1'b1, 1'b1, junk_op(), junk_bit(), WB, C_RW | C_DONE);
    end else if (opc == OP_BRANCH) begin
      push(1'b1, 1'b1, junk_op(), z, BR, C_AOP0 | C_DONE | (z ? (C_PCW | C_PCS) : 13'h0));
    end else begin
      ld = (opc == OP_LOAD);
      push(1'b1, 1'b1, junk_op(), junk_bit(), AD, C_ALUS);
      mem_wait(ME, C_ALUS | (ld ? C_MR : C_MW), mw, ok);
      if (!ok) return;
      if (ld) begin
        push(1'b1, 1'b1, junk_op(), junk_bit(), ME, C_ALUS | C_MR);
        push(1'b1, 1'b1, junk_op(), junk_bit(), WB, C_RW | C_M2R | C_DONE);
      end else begin
        push(1'b1, 1'b1, junk_op(), junk_bit(), ME, C_ALUS | C_MW | C_DONE);
      end
    end
  endtask

  task automatic reset_seq();
    push(1'b0, 1'b1, junk_op(), junk_bit(), ID, 13'h0);
    push(1'b0, 1'b1, junk_op(), junk_bit(), ID, 13'h0);
    push(1'b1, 1'b1, junk_op(), junk_bit(), ID, 13'h0);
  endtask

  initial begin
    int n;
    bit ok;
    logic [12:0] got;
    total = 0; bad = 0; done_cnt = 0; berr_cnt = 0;
    rst_n = 1'b0;
    bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;

    reset_seq();
    n = q.size(); instr(OP_RTYPE, 1'b0, 0, 0);  chk("len_rtype", q.size() - n, 4);
    n = q.size(); instr(OP_LOAD, 1'b0, 0, 3);   chk("len_load_wait3", q.size() - n, 8);
    instr(OP_STORE, 1'b0, 1, 0);
    n = q.size(); instr(OP_STORE, 1'b0, 0, 0);  chk("len_store", q.size() - n, 4);
    n = q.size(); instr(OP_BRANCH, 1'b1, 0, 0); chk("len_branch_taken", q.size() - n, 3);
    n = q.size(); instr(OP_BRANCH, 1'b0, 0, 0); chk("len_branch_not", q.size() - n, 3);
    n = q.size(); instr(7'h47, 1'b0, 0, 0);     chk("len_illegal", q.size() - n, 2);
    n = q.size(); instr(OP_STORE, 1'b0, 0, 16); chk("len_store_tmo", q.size() - n, 19);
    n = q.size(); instr(OP_LOAD, 1'b0, 0, 15);  chk("len_load_edge", q.size() - n, 20);
    n = q.size(); instr(OP_RTYPE, 1'b0, 16, 0); chk("len_fetch_tmo", q.size() - n, 16);
    instr(OP_RTYPE, 1'b0, 0, 0);
    // Store interrupted by reset while stalled in MEM.
    mem_wait(F, C_MR, 0, ok);
    push(1'b1, 1'b1, junk_op(), junk_bit(), F, C_MR | C_IRW | C_PCW);
    push(1'b1, 1'b0, OP_STORE, junk_bit(), D, 13'h0);
    push(1'b1, 1'b0, junk_op(), junk_bit(), AD, C_ALUS);
    push(1'b1, 1'b0, junk_op(), junk_bit(), ME, C_ALUS | C_MW);
    push(1'b1, 1'b0, junk_op(), junk_bit(), ME, C_ALUS | C_MW);
    reset_seq();
    instr(OP_RTYPE, 1'b0, 0, 0);
    n = q.size(); instr(OP_LOAD, 1'b0, 0, 0);   chk("len_load", q.size() - n, 5);

    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      rst_n         = q[i].rst;
      bus.mem_ready = q[i].rdy;
      bus.opcode    = q[i].opc;
      bus.zero      = q[i].z;
      #1;
      got = {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_src,
             bus.alu_op, bus.reg_write, bus.mem_to_reg, bus.instr_done, bus.illegal_op,
             bus.bus_err};
      if (bus.instr_done) done_cnt++;
      if (bus.bus_err) berr_cnt++;
      total++;
      if (got !== q[i].ctl || bus.state !== q[i].st) begin
        bad++;
        $display("FAIL cycle idx=%0d got state=%0d ctl=%h want state=%0d ctl=%h",
                 i, bus.state, got, q[i].st, q[i].ctl);
      end
    end

    chk("retire_count", done_cnt, 10);
    chk("bus_err_count", berr_cnt, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
